sweep_counter_ctrl: RTL and testbench
=====================================

// Module: sweep_counter_ctrl
// PURPOSE
//  Sequencer for a 4-bit up/down counter datapath. It runs programmable sweeps between a low bound
//  and a high bound, in up, down or ping-pong mode, for a set number of passes.
//  The counter register is contained in the block. Count/UpOrDown track the standalone counter's interface.
//  Sits between a config/host FSM (start/done handshake) and logic that consumes the sweep value.
// PARAMETERS
//  WIDTH   4  width of Count, lo, hi
//  PW      4  width of passes (pass counter)
// PORTS
//  Clk       in   1      clock, all logic on posedge
//  reset     in   1      synchronous, active-high reset
//  start     in   1      request sweep; sampled only in IDLE
//  mode      in   2      00 UP, 01 DOWN, 10 PINGPONG, 11 reserved
//  lo        in   WIDTH  low bound (inclusive)
//  hi        in   WIDTH  high bound (inclusive)
//  passes    in   PW     number of passes, 1..2^PW-1
//  pause     in   1      hold sweep while high
//  abort     in   1      terminate sweep without done
//  Count     out  WIDTH  current sweep value
//  UpOrDown  out  1      direction of the step leaving the current value (1=up)
//  busy      out  1      sweep in progress (RUN state)
//  done      out  1      1-cycle pulse: all passes complete
//  cfg_err   out  1      1-cycle pulse: start rejected
// BEHAVIOUR
//  Reset (sync): state IDLE, Count=0, UpOrDown=1, busy=0, done=0, cfg_err=0. Applies mid-sweep too, no done.
//  States: IDLE -> RUN -> DONE -> IDLE. RUN -> IDLE on abort.
//  IDLE + start: latch mode, lo, hi and passes.
//   - Reject if lo>hi, mode==11 or passes==0: cfg_err=1 for the next cycle. Stay IDLE. Count unchanged.
//   - Otherwise: Count<=start value (hi for DOWN, else lo), busy<=1, go to RUN.
//   - First RUN cycle shows the start value.
//  RUN (pause=0): each cycle Count advances one step. Count holds each value for exactly 1 cycle.
//   - UP: lo,lo+1..hi = one pass of (hi-lo+1) cycles. On more passes, hi -> lo. UpOrDown=1 throughout.
//   - DOWN: hi..lo = one pass of (hi-lo+1) cycles. On more passes, lo -> hi. UpOrDown=0 throughout.
//   - PINGPONG: lo..hi-1 with UpOrDown=1, then hi..lo+1 with UpOrDown=0.
//     One pass = 2*(hi-lo) cycles. Next pass restarts at lo.
//     If lo==hi, one pass = 1 cycle at lo, UpOrDown=1.
//   - Pass counter decrements at the last cycle of each pass.
//   - After the last cycle of the final pass: go to DONE, busy=0, done=1.
//  DONE (1 cycle): done=1. Count = end value (UP: hi, DOWN: lo, PINGPONG: lo). Then IDLE, done=0.
//  Bounds hold across the sweep: lo, hi, mode and passes are not resampled during RUN.
//  Count never leaves [lo,hi]. No 2^WIDTH wrap occurs (lo=0/hi=15 are legal full-range bounds).
//  pause=1 in RUN: Count, UpOrDown and the pass counter hold. busy stays 1.
//  abort=1 in RUN: next cycle IDLE, busy=0. done not pulsed, Count holds last value. abort beats pause.
//  abort in IDLE/DONE is ignored. start while busy or in DONE is ignored (no queuing).
//  Sweep latency: start edge -> busy after 1 edge. Total busy cycles = passes * pass length + pause cycles.
// TESTING
//  1 reset asserted 2 cycles (also mid-sweep) -> Count=0, UpOrDown=1, busy=0, done=0, cfg_err=0.
//  2 UP lo=3 hi=6 passes=2 -> Count 3,4,5,6,3,4,5,6 (busy 8 cycles), then done=1 with Count=6, then IDLE.
//  3 DOWN lo=0 hi=15 passes=1 -> Count 15..0 over 16 cycles, UpOrDown=0, done with Count=0.
//  4 PINGPONG lo=2 hi=5 passes=1 -> Count 2,3,4,5,4,3 with UpOrDown 1,1,1,0,0,0, done with Count=2.
//  5 start with lo=9 hi=4, then mode=11, then passes=0 -> cfg_err single pulse each, busy stays 0.
//  6 UP lo=0 hi=7: pause 3 cycles at Count=4 -> Count holds 4. Later abort at Count=6 -> busy=0 next cycle, no done.

Source files
------------

// File: rtl/sweep_counter_ctrl.sv
// Sweep sequencer wrapped around a WIDTH-bit up/down counter: UP, DOWN or
// PINGPONG sweeps between latched bounds for a programmed number of passes.
module sweep_counter_ctrl #(
    parameter int WIDTH = 4,
    parameter int PW    = 4
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [PW-1:0]    passes,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] Count,
    output logic             UpOrDown,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        M_UP       = 2'b00,
        M_DOWN     = 2'b01,
        M_PINGPONG = 2'b10,
        M_RSVD     = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [PW-1:0]    PONE = PW'(1);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;
    logic             pass_end;
    mode_e            mode_in;

    assign mode_in = mode_e'(mode);

    // Last cycle of a pass; a degenerate pingpong (lo==hi) ends every cycle.
    always_comb begin
        pass_end = 1'b1;
        case (mode_q)
            M_UP:       pass_end = (cnt_q == hi_q);
            M_DOWN:     pass_end = (cnt_q == lo_q);
            M_PINGPONG: pass_end = (lo_q == hi_q) || (!dir_q && (cnt_q == lo_q + ONE));
            default:    pass_end = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        pcnt_d  = pcnt_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d = mode_in;
                    lo_d   = lo;
                    hi_d   = hi;
                    pcnt_d = passes;
                    if ((lo > hi) || (mode_in == M_RSVD) || (passes == '0)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        cnt_d   = (mode_in == M_DOWN) ? hi : lo;
                        dir_d   = (mode_in != M_DOWN);
                    end
                end
            end

            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!pause) begin
                    if (pass_end) begin
                        pcnt_d = pcnt_q - PONE;
                        if (pcnt_q == PONE) begin
                            state_d = S_DONE;
                            // Pingpong finishes back at lo; UP/DOWN already sit on their end value.
                            if (mode_q == M_PINGPONG) begin
                                cnt_d = lo_q;
                                dir_d = 1'b1;
                            end
                        end else begin
                            cnt_d = (mode_q == M_DOWN) ? hi_q : lo_q;
                            dir_d = (mode_q != M_DOWN);
                        end
                    end else begin
                        case (mode_q)
                            M_UP:   cnt_d = cnt_q + ONE;
                            M_DOWN: cnt_d = cnt_q - ONE;
                            M_PINGPONG: begin
                                if (dir_q) begin
                                    cnt_d = cnt_q + ONE;
                                    dir_d = ((cnt_q + ONE) != hi_q);
                                end else begin
                                    cnt_d = cnt_q - ONE;
                                end
                            end
                            default: cnt_d = cnt_q;
                        endcase
                    end
                end
            end

            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= M_UP;
            lo_q    <= '0;
            hi_q    <= '0;
            pcnt_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            pcnt_q  <= pcnt_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    assign Count    = cnt_q;
    assign UpOrDown = dir_q;
    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign cfg_err  = err_q;

endmodule

// File: tb/tb_sweep_counter_ctrl.sv
// Scoreboard bench for sweep_counter_ctrl: sweeps are expanded into value lists
// from the sweep rules, and a negedge monitor checks every cycle the DUT reports.
module tb_sweep_counter_ctrl;

    localparam int K_RUN  = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;
    localparam int K_IDLE = 3;

    typedef struct {
        int kind;
        int cnt;
        int dir;
        bit chk_cnt;
        bit chk_dir;
    } exp_t;

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] mode = '0;
    logic [3:0] lo = '0;
    logic [3:0] hi = '0;
    logic [3:0] passes = '0;
    logic       pause = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] Count;
    logic       UpOrDown;
    logic       busy;
    logic       done;
    logic       cfg_err;
    logic       probe = 1'b0;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   last_cnt = 0;

    sweep_counter_ctrl #(.WIDTH(4), .PW(4)) dut (
        .Clk(Clk), .reset(reset), .start(start), .mode(mode), .lo(lo), .hi(hi),
        .passes(passes), .pause(pause), .abort(abort), .Count(Count),
        .UpOrDown(UpOrDown), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input int c, input int d, input bit cc, input bit cd);
        exp_t e;
        e.kind = kind; e.cnt = c; e.dir = d; e.chk_cnt = cc; e.chk_dir = cd;
        sbq.push_back(e);
    endtask

    // Expect a quiet IDLE cycle now, shown to the monitor through probe.
    task automatic probe_idle(input int c, input int d, input bit cd);
        push(K_IDLE, c, d, 1'b1, cd);
        probe = 1'b1;
        @(posedge Clk); #1;
        probe = 1'b0;
    endtask

    task automatic sweep(input int m, input int l, input int h, input int p, input bit rnd,
                         input int pause_val, input int abort_val, input int reset_cyc);
        int  seq[$];
        int  dsq[$];
        int  endv, idx, cyc, hold;
        bit  used, pa, ab, rs;
        mode   = m[1:0];
        lo     = l[3:0];
        hi     = h[3:0];
        passes = p[3:0];
        start  = 1'b1;
        abort  = rnd && ($urandom_range(0, 3) == 0);
        @(posedge Clk); #1;
        start = 1'b0;
        abort = 1'b0;
        if (rnd) begin
            lo = 4'($urandom); hi = 4'($urandom);
            mode = 2'($urandom); passes = 4'($urandom);
        end
        if (l > h || m == 3 || p == 0) begin
            push(K_ERR, last_cnt, 0, 1'b1, 1'b0);
            @(posedge Clk); #1;
            probe_idle(last_cnt, 0, 1'b0);
            return;
        end
        for (int k = 0; k < p; k++) begin
            if (m == 0) begin
                for (int v = l; v <= h; v++) begin seq.push_back(v); dsq.push_back(1); end
            end else if (m == 1) begin
                for (int v = h; v >= l; v--) begin seq.push_back(v); dsq.push_back(0); end
            end else if (l == h) begin
                seq.push_back(l); dsq.push_back(1);
            end else begin
                for (int v = l; v < h; v++) begin seq.push_back(v); dsq.push_back(1); end
                for (int v = h; v > l; v--) begin seq.push_back(v); dsq.push_back(0); end
            end
        end
        endv = (m == 0) ? h : l;
        idx = 0; cyc = 0; hold = 0; used = 1'b0;
        while (idx < seq.size()) begin
            push(K_RUN, seq[idx], dsq[idx], 1'b1, 1'b1);
            if (pause_val >= 0 && seq[idx] == pause_val && !used) begin
                hold = 3; used = 1'b1;
            end
            pa = (hold > 0) || (rnd && $urandom_range(0, 4) == 0);
            if (hold > 0) hold--;
            ab = (abort_val >= 0 && seq[idx] == abort_val) || (rnd && $urandom_range(0, 60) == 0);
            rs = (cyc == reset_cyc);
            pause = pa; abort = ab; reset = rs;
            start = rnd && ($urandom_range(0, 5) == 0);
            @(posedge Clk); #1;
            pause = 1'b0; abort = 1'b0; start = 1'b0;
            cyc++;
            if (rs) begin
                @(posedge Clk); #1;
                reset = 1'b0;
                last_cnt = 0;
                probe_idle(0, 1, 1'b1);
                return;
            end
            if (ab) begin
                last_cnt = seq[idx];
                probe_idle(last_cnt, 0, 1'b0);
                return;
            end
            if (!pa) idx++;
        end
        push(K_DONE, endv, 0, 1'b1, 1'b0);
        last_cnt = endv;
        abort = rnd && ($urandom_range(0, 1) == 0);
        start = rnd && ($urandom_range(0, 1) == 0);
        @(posedge Clk); #1;
        abort = 1'b0; start = 1'b0;
        probe_idle(endv, 0, 1'b0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (busy || done || cfg_err || probe) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output busy=%0d done=%0d cfg_err=%0d required none at %0t",
                             busy, done, cfg_err, $time);
                end else begin
                    e = sbq.pop_front();
                    chk("busy", int'(busy), int'(e.kind == K_RUN));
                    chk("done", int'(done), int'(e.kind == K_DONE));
                    chk("cfg_err", int'(cfg_err), int'(e.kind == K_ERR));
                    if (e.chk_cnt) chk("Count", int'(Count), e.cnt);
                    if (e.chk_dir) chk("UpOrDown", int'(UpOrDown), e.dir);
                end
            end
        end
    end

    initial begin
        int m, l, h, p, r, rc;
        reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        reset = 1'b0;
        probe_idle(0, 1, 1'b1);

        sweep(0, 3, 6, 2, 1'b0, -1, -1, -1);
        sweep(1, 0, 15, 1, 1'b0, -1, -1, -1);
        sweep(2, 2, 5, 1, 1'b0, -1, -1, -1);
        sweep(0, 9, 4, 1, 1'b0, -1, -1, -1);
        sweep(3, 1, 4, 1, 1'b0, -1, -1, -1);
        sweep(0, 1, 4, 0, 1'b0, -1, -1, -1);
        sweep(0, 0, 7, 1, 1'b0, 4, 6, -1);
        sweep(0, 1, 10, 3, 1'b0, -1, -1, 5);
        sweep(2, 7, 7, 3, 1'b0, -1, -1, -1);
        sweep(2, 14, 15, 2, 1'b0, -1, -1, -1);
        sweep(1, 5, 5, 2, 1'b0, -1, -1, -1);

        for (int t = 0; t < 40; t++) begin
            r  = $urandom_range(0, 19);
            m  = (r == 0) ? 3 : (r % 3);
            l  = $urandom_range(0, 15);
            h  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(l, 15);
            p  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
            rc = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 10) : -1;
            sweep(m, l, h, p, 1'b1, -1, -1, rc);
        end

        repeat (3) @(posedge Clk);
        #1;
        chk("scoreboard_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
